wb_regfile: RTL and testbench

Writeback-end register file for the 5-stage pipeline. It consumes the MEM/WB register outputs (memory read data, ALU result, destination register, PC+4), selects the writeback result, and commits it to a 2^N-entry register file. It serves the two decode-stage read ports with same-cycle write-through bypass. After reset it clears every register with an internal sequencer and holds `busy` high until the clear completes.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_result_mux.sv | 28 ++
 rtl/wb_regfile.sv | 127 ++++++++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-end register file: default widths,
// result-select encodings and the clear/run sequencer states.
package wb_pkg;

  // Default data/address width and register index width.
  localparam int M_DEF = 32;
  localparam int N_DEF = 5;

  // Result-select encodings presented on resultSrcW.
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_NONE = 2'b11;

  // Sequencer states: CLEAR zeroes one entry per edge, RUN serves the pipeline.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

  // True when the select code produces a value that may be committed.
  function automatic logic res_writes(input logic [1:0] sel);
    return sel != RES_NONE;
  endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Combinational writeback result selector. Also instantiated by the EX
// forwarding path, so it carries no state and no enable logic.
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic [1:0]   i_sel,
  input  logic [M-1:0] i_alu,
  input  logic [M-1:0] i_mem,
  input  logic [M-1:0] i_pc4,
  output logic [M-1:0] o_result
);

  // Pick the writeback source; the reserved code yields zero.
  always_comb begin
    // NOTE: o_result is assigned before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    o_result = '0;
    case (i_sel)
      RES_ALU: o_result = i_alu;
      RES_MEM: o_result = i_mem;
      RES_PC4: o_result = i_pc4;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-end register file: selects the WB result, commits it to a
// 2^N x M flop array, serves two combinational read ports with same-cycle
// write-through bypass, and zeroes the whole array after reset using an
// internal sequencer while holding busy high.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [M-1:0] RDW,
  input  logic [M-1:0] ALUW,
  input  logic [N-1:0] writeRW,
  input  logic [M-1:0] pcPlusW,
  input  logic         regWriteW,
  input  logic [1:0]   resultSrcW,
  input  logic [N-1:0] RA1,
  input  logic [N-1:0] RA2,
  output logic [M-1:0] RD1,
  output logic [M-1:0] RD2,
  output logic [M-1:0] resultW,
  output logic         busy
);

  localparam int DEPTH = 1 << N;

  wb_state_t      r_state;
  logic [N-1:0]   r_ptr;
  logic           r_busy;
  logic [M-1:0]   r_regs [DEPTH];

  logic [M-1:0]   w_result;
  logic           w_run;
  logic           w_commit;
  logic           w_mem_we;
  logic [N-1:0]   w_mem_addr;
  logic [M-1:0]   w_mem_data;

  wb_result_mux #(.M(M)) u_result_mux (
    .i_sel    (resultSrcW),
    .i_alu    (ALUW),
    .i_mem    (RDW),
    .i_pc4    (pcPlusW),
    .o_result (w_result)
  );

  assign resultW = w_result;
  assign busy    = r_busy;
  assign w_run   = (r_state == RUN);

  // A commit needs RUN, an enabled write, a non-zero target and a real source.
  assign w_commit = w_run && regWriteW && (writeRW != '0) && res_writes(resultSrcW);

  // Storage port: the sequencer owns it in CLEAR, the WB stage in RUN.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = writeRW;
    w_mem_data = w_result;
    if (!w_run) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_ptr;
      w_mem_data = '0;
    end else if (w_commit) begin
      w_mem_we   = 1'b1;
    end
  end

  // Clear/run sequencer; reset restarts the clear from entry 0 in any state.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RSTn) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == '1) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_ptr  <= r_ptr;
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Register array write; one entry per edge, held off while reset is low.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset branch; the sequencer zeroes it entry by
    // entry, which keeps it a plain enable-write flop array.
    if (RSTn && w_mem_we) begin
      r_regs[w_mem_addr] <= w_mem_data;
    end
  end

  // Read port 1: zero in CLEAR or for x0, bypass on a matching commit.
  always_comb begin
    RD1 = '0;
    if (w_run && (RA1 != '0)) begin
      if (w_commit && (writeRW == RA1)) RD1 = w_result;
      else                              RD1 = r_regs[RA1];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    RD2 = '0;
    if (w_run && (RA2 != '0)) begin
      if (w_commit && (writeRW == RA2)) RD2 = w_result;
      else                              RD2 = r_regs[RA2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: an abstract model (array + clear
// countdown) checked every cycle, plus directed literal expectations.
module tb_wb_regfile;
  import wb_pkg::*;

  localparam int M = 32;
  localparam int N = 5;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         RSTn = 1'b1;
  logic [M-1:0] RDW = '0, ALUW = '0, pcPlusW = '0;
  logic [N-1:0] writeRW = '0, RA1 = '0, RA2 = '0;
  logic         regWriteW = 1'b0;
  logic [1:0]   resultSrcW = 2'b00;
  logic [M-1:0] RD1, RD2, resultW;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile #(.M(M), .N(N)) dut (
    .CLK(clk), .RSTn(RSTn), .RDW(RDW), .ALUW(ALUW), .writeRW(writeRW),
    .pcPlusW(pcPlusW), .regWriteW(regWriteW), .resultSrcW(resultSrcW),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .resultW(resultW), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [M-1:0] m_regs [DEPTH];
  int           m_clear_left = 0;
  bit           m_valid = 0;

  function automatic logic [M-1:0] m_result();
    case (resultSrcW)
      2'd0: return ALUW;
      2'd1: return RDW;
      2'd2: return pcPlusW;
      default: return '0;
    endcase
  endfunction

  function automatic bit m_busy();
    return m_clear_left > 0;
  endfunction

  function automatic bit m_commit();
    return !m_busy() && regWriteW && writeRW != 0 && resultSrcW != 2'd3;
  endfunction

  function automatic logic [M-1:0] m_read(input logic [N-1:0] ra);
    if (m_busy() || ra == 0) return '0;
    if (m_commit() && writeRW == ra) return m_result();
    return m_regs[ra];
  endfunction

  // Model advances on each rising edge from the pre-edge inputs.
  always @(posedge clk) begin
    if (!RSTn) begin
      m_valid      = 1;
      m_clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (m_commit()) begin
      m_regs[writeRW] = m_result();
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    check("resultW", resultW, m_result());
    if (m_valid) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy()});
      check("RD1", RD1, m_read(RA1));
      check("RD2", RD2, m_read(RA2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [N-1:0] rd, input logic [1:0] sel,
                    input logic [M-1:0] alu, input logic [M-1:0] mem, input logic [M-1:0] pc4);
    regWriteW = we; writeRW = rd; resultSrcW = sel;
    ALUW = alu; RDW = mem; pcPlusW = pc4;
  endtask

  // Counts edges with RSTn high until busy falls, bounded.
  task automatic count_clear(output int edges);
    edges = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      edges++;
      if (!busy) break;
    end
  endtask

  int edges;

  initial begin
    // Reset: two low edges, then count the clear.
    RSTn = 1'b0;
    tick(); tick();
    check("busy_after_reset", {31'b0, busy}, 32'd1);
    check("rd1_in_reset", RD1, 32'h0);
    RSTn = 1'b1;
    count_clear(edges);
    check("clear_edges", edges, 32'd32);

    // Every register reads zero after the clear.
    for (int i = 0; i < DEPTH; i++) begin
      RA1 = i[N-1:0]; RA2 = 5'(DEPTH - 1 - i);
      #1;
      check("cleared_rd1", RD1, 32'h0);
      check("cleared_rd2", RD2, 32'h0);
    end

    // Write/readback with same-cycle bypass.
    wb(1, 5'd5, RES_ALU, 32'hDEADBEEF, 32'h0, 32'h0);
    RA1 = 5'd5; RA2 = 5'd6;
    #1;
    check("bypass_r5", RD1, 32'hDEADBEEF);
    tick();
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);
    #1;
    check("stored_r5", RD1, 32'hDEADBEEF);
    check("model_r5", m_regs[5], 32'hDEADBEEF);

    // Result select: memory, PC+4, reserved.
    wb(1, 5'd7, RES_MEM, 32'h0, 32'h1234, 32'h0);
    #1; check("resultW_mem", resultW, 32'h1234);
    tick();
    wb(1, 5'd31, RES_PC4, 32'h0, 32'h0, 32'h40);
    #1; check("resultW_pc4", resultW, 32'h40);
    tick();
    wb(1, 5'd8, RES_NONE, 32'hFF, 32'h0, 32'h0);
    RA1 = 5'd8;
    #1;
    check("resultW_none", resultW, 32'h0);
    check("no_bypass_r8", RD1, 32'h0);
    tick();
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);
    RA1 = 5'd7; RA2 = 5'd31;
    #1;
    check("r7", RD1, 32'h1234);
    check("r31", RD2, 32'h40);
    check("model_r7", m_regs[7], 32'h1234);
    RA1 = 5'd8;
    #1;
    check("r8_unchanged", RD1, 32'h0);

    // Zero register.
    wb(1, 5'd0, RES_ALU, 32'hFFFFFFFF, 32'h0, 32'h0);
    RA1 = 5'd0; RA2 = 5'd0;
    #1;
    check("x0_wcycle_rd1", RD1, 32'h0);
    check("x0_wcycle_rd2", RD2, 32'h0);
    tick();
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);
    #1;
    check("x0_after_rd1", RD1, 32'h0);

    // Dual bypass.
    wb(1, 5'd9, RES_ALU, 32'hA5A5A5A5, 32'h0, 32'h0);
    RA1 = 5'd9; RA2 = 5'd9;
    #1;
    check("dual_rd1", RD1, 32'hA5A5A5A5);
    check("dual_rd2", RD2, 32'hA5A5A5A5);
    tick();
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);

    // Reset mid-clear with writes attempted during busy.
    wb(1, 5'd3, RES_ALU, 32'h55, 32'h0, 32'h0);
    tick();
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);
    RA1 = 5'd3;
    #1;
    check("r3_before_reset", RD1, 32'h55);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    wb(1, 5'd4, RES_ALU, 32'h77, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) tick();
    check("busy_mid_clear", {31'b0, busy}, 32'd1);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    wb(1, 5'd3, RES_ALU, 32'h99, 32'h0, 32'h0);
    count_clear(edges);
    wb(0, 5'd0, RES_ALU, 32'h0, 32'h0, 32'h0);
    check("restart_clear_edges", edges, 32'd32);
    RA1 = 5'd3; RA2 = 5'd4;
    #1;
    check("r3_cleared", RD1, 32'h0);
    check("r4_dropped", RD2, 32'h0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
